// File: rtl/buf_pkg.sv
// Shared constants and types for the buffer read-side controller.
package buf_pkg;
  localparam int BUF_AW    = 9;
  localparam int PTR_W     = BUF_AW + 1;
  localparam int BUF_BYTES = 1 << BUF_AW;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [7:0]       byte_t;
endpackage

// File: rtl/buf_skid2.sv
// Two-entry holding stage: out register (oldest byte) plus one skid slot.
// A push lands in the out register if it is empty after this cycle's pop,
// otherwise in the skid slot; a pop promotes the skid byte when present.
module buf_skid2
  import buf_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       push,
  input  byte_t      push_data,
  input  logic       pop,
  output byte_t      out_data,
  output logic       out_valid,
  output logic [1:0] occ
);
  byte_t      skid;
  logic [1:0] occ_after_pop;
  logic [1:0] occ_next;

  // pop is only ever asserted with out_valid, so occ >= 1 whenever it is set
  assign occ_after_pop = occ - {1'b0, pop};
  assign occ_next      = occ_after_pop + {1'b0, push};

  // holding-stage state; flush discards everything including a same-cycle push
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ       <= 2'd0;
      out_valid <= 1'b0;
      out_data  <= '0;
      skid      <= '0;
    end else if (flush) begin
      occ       <= 2'd0;
      out_valid <= 1'b0;
    end else begin
      if (pop && occ == 2'd2) out_data <= skid;
      if (push) begin
        if (occ_after_pop == 2'd0) out_data <= push_data;
        else                       skid     <= push_data;
      end
      occ       <= occ_next;
      out_valid <= (occ_next != 2'd0);
    end
  end
endmodule

// File: rtl/buf_reader.sv
// Read-side controller for the 512-byte dual-port buffer. Fetches bytes over
// the 1-clock-latency read port and presents them as a valid/ready stream.
// fptr runs at most two bytes ahead of rdptr (holding capacity), so the
// stream never stalls at full rate and never overruns under backpressure.
module buf_reader
  import buf_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PTR_W-1:0]  wrptr,
  input  logic              flush,
  output logic [BUF_AW-1:0] rdaddr,
  input  logic [7:0]        memdata,
  output logic [PTR_W-1:0]  rdptr,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              empty,
  output logic [PTR_W-1:0]  level
);
  ptr_t       fptr;
  logic       inflight;
  logic [1:0] occ;
  logic       pop;
  logic       has_room;
  logic       issue;

  assign pop      = out_valid & out_ready;
  // bytes held plus byte on its way must leave a free slot for a new fetch
  assign has_room = ({1'b0, occ} + {2'b0, inflight}) < 3'd2;
  assign issue    = (fptr != wrptr) & (has_room | pop);

  assign rdaddr = fptr[BUF_AW-1:0];
  assign empty  = (wrptr == rdptr);
  assign level  = wrptr - rdptr;

  // fetch/consume pointers and read-in-flight flag; flush realigns to writer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fptr     <= '0;
      rdptr    <= '0;
      inflight <= 1'b0;
    end else if (flush) begin
      fptr     <= wrptr;
      rdptr    <= wrptr;
      inflight <= 1'b0;
    end else begin
      if (issue) fptr  <= fptr + PTR_W'(1);
      if (pop)   rdptr <= rdptr + PTR_W'(1);
      inflight <= issue;
    end
  end

  buf_skid2 u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (inflight),
    .push_data (memdata),
    .pop       (pop),
    .out_data  (out_data),
    .out_valid (out_valid),
    .occ       (occ)
  );
endmodule

// File: tb/tb_buf_reader.sv
// Self-checking bench for buf_reader: memory model, byte-queue reference,
// scenario table with randomized writer/consumer, plus hand-written corners.
module tb_buf_reader;
  import buf_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [PTR_W-1:0]  wrptr = '0;
  logic              flush = 1'b0;
  logic [BUF_AW-1:0] rdaddr;
  logic [7:0]        memdata;
  logic [PTR_W-1:0]  rdptr;
  logic [7:0]        out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              empty;
  logic [PTR_W-1:0]  level;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [BUF_BYTES];
  byte unsigned q[$];
  int m_wr = 0;
  int m_rd = 0;

  typedef struct {
    int start;
    int pre;
    int n;
    int wpct;
    int rpct;
    int exp_rd;
    bit contig;
  } scen_t;

  buf_reader dut (
    .clk(clk), .rst_n(rst_n), .wrptr(wrptr), .flush(flush), .rdaddr(rdaddr),
    .memdata(memdata), .rdptr(rdptr), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .empty(empty), .level(level)
  );

  always #5 clk = ~clk;

  // buffer memory: registered read, 1-clock latency
  always @(posedge clk) memdata <= mem[rdaddr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // writer commits byte b at the current model write pointer
  task automatic write_byte(input byte unsigned b);
    mem[m_wr % BUF_BYTES] = b;
    q.push_back(b);
    m_wr = (m_wr + 1) % 1024;
    wrptr = m_wr[PTR_W-1:0];
  endtask

  task automatic run(input scen_t s);
    int sent, got, cyc, first, last, ahead;
    bit pstall;
    logic [7:0] pdata;
    byte unsigned exp_b;
    sent = 0; got = 0; cyc = 0; first = -1; last = -1; pstall = 0; pdata = '0;
    // realign all pointers to the scenario start via flush
    @(posedge clk); #1;
    out_ready = 0; wrptr = s.start[PTR_W-1:0]; flush = 1;
    @(posedge clk); #1;
    flush = 0;
    m_wr = s.start; m_rd = s.start; q.delete();
    if (s.pre > 0) begin
      for (int i = 0; i < s.pre; i++) write_byte(8'($urandom_range(255)));
      sent = s.pre;
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("preload_level", level, s.pre % 1024);
      chk("preload_empty", empty, 0);
      chk("preload_valid", out_valid, 1);
      @(posedge clk); #1;
    end
    while (got < s.n && cyc < 20000) begin
      out_ready = ($urandom_range(99) < s.rpct);
      if (sent < s.n && ((m_wr - m_rd) & 1023) < 512 && $urandom_range(99) < s.wpct) begin
        write_byte(8'($urandom_range(255)));
        sent++;
      end
      @(negedge clk);
      chk("rdptr", rdptr, m_rd);
      chk("level", level, (m_wr - m_rd) & 1023);
      chk("empty", empty, (m_wr == m_rd));
      ahead = (int'(rdaddr) - (m_rd % BUF_BYTES)) & 511;
      if (ahead > 2) chk("fetch_ahead", ahead, 2);
      if (pstall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, pdata);
      end
      pstall = out_valid & !out_ready;
      pdata = out_data;
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("spurious_byte", out_valid, 0);
        else begin
          exp_b = q.pop_front();
          chk("data", out_data, exp_b);
        end
        if (first < 0) first = cyc;
        last = cyc;
        got++;
        m_rd = (m_rd + 1) % 1024;
      end
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 0;
    chk("completion", got, s.n);
    @(negedge clk);
    chk("final_rdptr", rdptr, s.exp_rd);
    chk("final_level", level, 0);
    chk("final_empty", empty, 1);
    if (s.contig) chk("throughput", last - first, s.n - 1);
  endtask

  initial begin
    scen_t tbl[5];
    int base, waited;
    tbl[0] = '{start: 0,    pre: 0,   n: 512, wpct: 100, rpct: 100, exp_rd: 512, contig: 1};
    tbl[1] = '{start: 1020, pre: 0,   n: 10,  wpct: 100, rpct: 100, exp_rd: 6,   contig: 1};
    tbl[2] = '{start: 200,  pre: 0,   n: 400, wpct: 100, rpct: 30,  exp_rd: 600, contig: 0};
    tbl[3] = '{start: 900,  pre: 0,   n: 300, wpct: 60,  rpct: 70,  exp_rd: 176, contig: 0};
    tbl[4] = '{start: 700,  pre: 512, n: 600, wpct: 100, rpct: 100, exp_rd: 276, contig: 0};

    for (int i = 0; i < BUF_BYTES; i++) mem[i] = '0;

    // reset state
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_rdptr", rdptr, 0);
    chk("rst_rdaddr", rdaddr, 0);
    chk("rst_empty", empty, 1);
    chk("rst_level", level, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    // single byte: visible two edges after the writer pointer advances
    @(posedge clk); #1;
    out_ready = 1;
    mem[0] = 8'hA5; wrptr = 10'd1;
    @(negedge clk); chk("lat_e0_valid", out_valid, 0);
    @(negedge clk); chk("lat_e1_valid", out_valid, 0);
    @(negedge clk); chk("lat_e2_valid", out_valid, 1);
    chk("lat_data", out_data, 8'hA5);
    @(negedge clk);
    chk("single_rdptr", rdptr, 1);
    chk("single_empty", empty, 1);
    chk("single_valid", out_valid, 0);

    // scenario table
    for (int i = 0; i < 5; i++) run(tbl[i]);

    // flush while one byte held and one read in flight
    @(posedge clk); #1;
    out_ready = 0;
    base = m_wr;
    for (int i = 0; i < 3; i++) write_byte(8'(8'h10 + i));
    @(posedge clk);
    @(posedge clk); #1;
    chk("preflush_valid", out_valid, 1);
    flush = 1;
    @(posedge clk); #1;
    flush = 0;
    q.delete();
    m_rd = m_wr;
    @(negedge clk);
    chk("flush_valid", out_valid, 0);
    chk("flush_rdptr", rdptr, (base + 3) & 1023);
    chk("flush_rdaddr", rdaddr, (base + 3) & 511);
    chk("flush_level", level, 0);
    @(posedge clk); #1;
    write_byte(8'h3C);
    out_ready = 1;
    waited = 0;
    @(negedge clk);
    while (!out_valid && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    chk("postflush_arrive", out_valid, 1);
    chk("postflush_data", out_data, 8'h3C);
    @(negedge clk);
    chk("postflush_rdptr", rdptr, (base + 4) & 1023);
    chk("postflush_valid", out_valid, 0);

    // asynchronous reset mid-stream clears everything immediately
    @(posedge clk); #1;
    out_ready = 0;
    for (int i = 0; i < 4; i++) write_byte(8'(8'hC0 + i));
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("prereset_valid", out_valid, 1);
    #2;
    rst_n = 0; wrptr = '0; m_wr = 0; m_rd = 0; q.delete();
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_rdptr", rdptr, 0);
    chk("async_rst_level", level, 0);
    chk("async_rst_empty", empty, 1);
    chk("async_rst_rdaddr", rdaddr, 0);
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    chk("post_rst_valid", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
